hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller; generates the flush/stall controls that the IF/ID and ID/EX pipeline registers consume.
- Drives reset_IF_ID / reset_ID_EX (reset_t: RESET_CONTINUE / RESET_RESET) and the PC/IF-ID hold enables.
- Resolves EX-stage redirects, load-use hazards and memory/multi-cycle-EX stalls.
- Holds a redirect that arrives while an instruction fetch is outstanding (Iwait) until that fetch returns.

Parameters:
- XLEN, 64, width of PC/redirect target
- CNT_W, 32, width of flush performance counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- id_rs1, id_rs2  in  5 each  decode-stage source registers
- id_use_rs1, id_use_rs2  in  1 each  source actually read
- ex_dst  in  5  EX-stage destination
- ex_regwrite  in  1  EX instr writes a register
- ex_is_load  in  1  EX instr is a load
- ex_redirect  in  1  EX resolved taken branch/jump (valid only for a non-bubble instruction)
- ex_target  in  XLEN  redirect target
- Iwait  in  1  instruction fetch outstanding
- Dwait  in  1  data memory outstanding
- exe_is_waiting  in  1  multi-cycle EX unit busy
- reset_IF_ID  out  reset_t  flush IF/ID
- reset_ID_EX  out  reset_t  flush ID/EX
- stall_pc  out  1  hold PC
- stall_IF_ID  out  1  hold IF/ID register
- redirect_valid  out  1  load PC with redirect_pc
- redirect_pc  out  XLEN  redirect target
- flush_count  out  CNT_W  count of redirects applied

Behaviour:
- Registered state: fsm ∈ {IDLE, PEND}; pend_pc[XLEN]; flush_count.
- All other outputs are combinational from state and inputs.
- Reset (async): fsm=IDLE, pend_pc=0, flush_count=0.
- While reset is high, the outputs are:
  - reset_IF_ID = reset_ID_EX = RESET_RESET
  - stall_pc = 0, stall_IF_ID = 0, redirect_valid = 0, redirect_pc = 0
- gstall = Dwait | exe_is_waiting. Priority: gstall > redirect/PEND > load-use.
- gstall=1 (any state):
  - Both reset_* = RESET_CONTINUE; stall_pc = stall_IF_ID = 1; redirect_valid = 0.
  - State, pend_pc and counter are unchanged; a concurrent ex_redirect is ignored (EX is held, so it re-presents next cycle).
- IDLE, ex_redirect=1, Iwait=0:
  - redirect_valid = 1, redirect_pc = ex_target.
  - Both reset_* = RESET_RESET; stalls = 0.
  - flush_count += 1; fsm stays IDLE.
- IDLE, ex_redirect=1, Iwait=1:
  - pend_pc <= ex_target; fsm <= PEND.
  - reset_ID_EX = RESET_RESET, reset_IF_ID = RESET_CONTINUE.
  - stall_pc = stall_IF_ID = 1; redirect_valid = 0.
- PEND, Iwait=1:
  - reset_ID_EX = RESET_RESET every cycle (inject bubbles).
  - stall_pc = stall_IF_ID = 1; redirect_valid = 0.
  - ex_redirect is ignored.
- PEND, Iwait=0:
  - redirect_valid = 1, redirect_pc = pend_pc.
  - Both reset_* = RESET_RESET (discard wrong-path fetch); stalls = 0.
  - flush_count += 1; fsm <= IDLE.
- Load-use (IDLE, no gstall, no redirect):
  - Hazard: ex_is_load & ex_regwrite & ex_dst≠0 & ((id_use_rs1 & id_rs1==ex_dst) | (id_use_rs2 & id_rs2==ex_dst)).
  - Response: stall_pc = stall_IF_ID = 1, reset_ID_EX = RESET_RESET, reset_IF_ID = RESET_CONTINUE.
  - Exactly one bubble per load; next cycle the load is in MEM and forwarding covers it.
- Otherwise: both reset_* = RESET_CONTINUE, stalls 0, redirect_valid 0, redirect_pc = 0.
- flush_count wraps modulo 2^CNT_W.
- Reset mid-PEND: pending redirect is dropped; fsm returns to IDLE.

Decomposition:
- reset_t (RESET_CONTINUE/RESET_RESET) stays in common package.
- Add to common package: hazard_state_t {HZ_IDLE, HZ_PEND}; constant REG_ZERO = 5'd0.
- One natural sub-module: hazard_loaduse_detect (combinational comparator for rs1/rs2 vs ex_dst).

Test Plan:
- Load x5 in EX, ID reads rs1=5 (use=1), all waits 0 → one cycle: stall_pc=1, stall_IF_ID=1, reset_ID_EX=RESET, reset_IF_ID=CONTINUE; next cycle (ex_is_load=0) → all CONTINUE.
- ex_redirect=1, ex_target=0x8000_0040, Iwait=0 → same cycle: redirect_valid=1, redirect_pc=0x8000_0040, both RESET; flush_count 0→1.
- ex_redirect=1, target 0x8000_0100, Iwait=1 for 3 cycles then 0:
  - PEND for 3 cycles: reset_ID_EX=RESET, stalls=1, redirect_valid=0.
  - Cycle Iwait drops: redirect_valid=1, redirect_pc=0x8000_0100, both RESET; then IDLE.
- Dwait=1 during PEND → all CONTINUE, stalls=1, pend_pc held. Dwait drops with Iwait=0 → redirect issued with held pend_pc.
- Assert reset asynchronously while in PEND → immediately both RESET, redirect_valid=0, flush_count=0. After release, fsm=IDLE and no redirect is issued.
- Load to x0 with ID rs1=0, plus the simultaneous case load-use + ex_redirect:
  - x0 case → no stall.
  - Simultaneous case → redirect wins: redirect_valid=1, no stall_pc.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
//
// Shared types and constants for the pipeline hazard controller.
//
//   reset_t        : per-pipeline-register flush command (continue / reset)
//   hazard_state_t : redirect FSM state (idle / redirect pending on Iwait)
//   REG_ZERO       : architectural zero register; never a real dependency
//   src_matches()  : one source operand depends on a given destination
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        RESET_CONTINUE = 1'b0,
        RESET_RESET    = 1'b1
    } reset_t;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_PEND = 1'b1
    } hazard_state_t;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // True when the decode-stage operand is actually read and names dst.
    function automatic logic src_matches(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//
// Bundle between the pipeline datapath and the hazard controller.
//
//   Pipeline -> controller : id_rs1, id_rs2, id_use_rs1, id_use_rs2,
//                            ex_dst, ex_regwrite, ex_is_load, ex_redirect,
//                            ex_target, Iwait, Dwait, exe_is_waiting
//   Controller -> pipeline : reset_IF_ID, reset_ID_EX, stall_pc, stall_IF_ID,
//                            redirect_valid, redirect_pc, flush_count
//
//   master : pipeline side (drives hazard sources, consumes controls)
//   slave  : hazard controller side
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) ();
    import hazard_ctrl_pkg::*;

    // Decode stage
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;

    // Execute stage
    logic [REG_ADDR_W-1:0] ex_dst;
    logic                  ex_regwrite;
    logic                  ex_is_load;
    logic                  ex_redirect;
    logic [XLEN-1:0]       ex_target;

    // Memory / multi-cycle status
    logic                  Iwait;
    logic                  Dwait;
    logic                  exe_is_waiting;

    // Controls back to the pipeline
    reset_t                reset_IF_ID;
    reset_t                reset_ID_EX;
    logic                  stall_pc;
    logic                  stall_IF_ID;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_dst, ex_regwrite, ex_is_load, ex_redirect, ex_target,
        output Iwait, Dwait, exe_is_waiting,
        input  reset_IF_ID, reset_ID_EX, stall_pc, stall_IF_ID,
        input  redirect_valid, redirect_pc, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_dst, ex_regwrite, ex_is_load, ex_redirect, ex_target,
        input  Iwait, Dwait, exe_is_waiting,
        output reset_IF_ID, reset_ID_EX, stall_pc, stall_IF_ID,
        output redirect_valid, redirect_pc, flush_count
    );

endinterface

// File: rtl/hazard_loaduse_detect.sv
// -----------------------------------------------------------------------------
// hazard_loaduse_detect
//
// Purely combinational load-use dependency check: flags when the instruction
// in decode reads a register that the load currently in EX will write. The
// loaded value is only available after MEM, so decode must wait one cycle.
//
//   id_rs1_i, id_rs2_i         : decode-stage source registers
//   id_use_rs1_i, id_use_rs2_i : the corresponding source is actually read
//   ex_dst_i                   : EX-stage destination register
//   ex_regwrite_i              : EX instruction writes a register
//   ex_is_load_i               : EX instruction is a load
//   hazard_o                   : one-bubble load-use stall required
// -----------------------------------------------------------------------------
module hazard_loaduse_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_dst_i,
    input  logic                  ex_regwrite_i,
    input  logic                  ex_is_load_i,
    output logic                  hazard_o
);

    logic load_writes_reg;
    logic rs1_dep;
    logic rs2_dep;

    // Writes to x0 are discarded, so a load targeting x0 never creates a
    // dependency even if decode names x0 as a source.
    assign load_writes_reg = ex_is_load_i && ex_regwrite_i && (ex_dst_i != REG_ZERO);

    assign rs1_dep = src_matches(id_use_rs1_i, id_rs1_i, ex_dst_i);
    assign rs2_dep = src_matches(id_use_rs2_i, id_rs2_i, ex_dst_i);

    assign hazard_o = load_writes_reg && (rs1_dep || rs2_dep);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller. Produces the flush (reset_IF_ID / reset_ID_EX)
// and hold (stall_pc / stall_IF_ID) controls for the front of the pipeline
// and the PC redirect request.
//
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : hazard_ctrl_if.slave
//             in : decode sources, EX destination/load/redirect info,
//                  Iwait, Dwait, exe_is_waiting
//             out: reset_IF_ID, reset_ID_EX, stall_pc, stall_IF_ID,
//                  redirect_valid, redirect_pc, flush_count
//
// Priority, highest first:
//   1. global stall (Dwait | exe_is_waiting): freeze everything
//   2. redirect, either fresh from EX or pending behind an outstanding fetch
//   3. load-use: hold IF/PC one cycle and inject one bubble into ID/EX
//
// A redirect that resolves while an instruction fetch is in flight cannot be
// applied yet (the returning fetch would overwrite it), so its target is
// parked in pend_pc_q and the FSM waits in HZ_PEND, bubbling ID/EX, until
// Iwait drops.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    hazard_state_t    state_q,       state_d;
    logic [XLEN-1:0]  pend_pc_q,     pend_pc_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // -------------------------------------------------------------------------
    // Combinational outputs
    // -------------------------------------------------------------------------
    reset_t           reset_if_id;
    reset_t           reset_id_ex;
    logic             stall_pc;
    logic             stall_if_id;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;

    logic             gstall;
    logic             load_use;

    assign gstall = bus.Dwait || bus.exe_is_waiting;

    hazard_loaduse_detect u_loaduse (
        .id_rs1_i      (bus.id_rs1),
        .id_rs2_i      (bus.id_rs2),
        .id_use_rs1_i  (bus.id_use_rs1),
        .id_use_rs2_i  (bus.id_use_rs2),
        .ex_dst_i      (bus.ex_dst),
        .ex_regwrite_i (bus.ex_regwrite),
        .ex_is_load_i  (bus.ex_is_load),
        .hazard_o      (load_use)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HZ_IDLE;
            pend_pc_q     <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_pc_q     <= pend_pc_d;
            flush_count_q <= flush_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every variable driven here gets a default first; any path that
    // left one unassigned would infer a latch.
    always_comb begin
        state_d        = state_q;
        pend_pc_d      = pend_pc_q;
        flush_count_d  = flush_count_q;

        reset_if_id    = RESET_CONTINUE;
        reset_id_ex    = RESET_CONTINUE;
        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        if (reset) begin
            // Registers are being cleared; hold both pipeline registers in
            // reset so nothing stale escapes while the core comes up.
            reset_if_id = RESET_RESET;
            reset_id_ex = RESET_RESET;
        end else if (gstall) begin
            // The whole pipe is frozen. A redirect from EX is ignored here
            // because EX is held too and will present it again.
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
        end else begin
            unique case (state_q)
                HZ_IDLE: begin
                    if (bus.ex_redirect) begin
                        if (!bus.Iwait) begin
                            redirect_valid = 1'b1;
                            redirect_pc    = bus.ex_target;
                            reset_if_id    = RESET_RESET;
                            reset_id_ex    = RESET_RESET;
                            flush_count_d  = flush_count_q + CNT_W'(1);
                        end else begin
                            // Fetch in flight: park the target, kill the
                            // wrong-path decode instruction, hold the front.
                            pend_pc_d   = bus.ex_target;
                            state_d     = HZ_PEND;
                            reset_id_ex = RESET_RESET;
                            stall_pc    = 1'b1;
                            stall_if_id = 1'b1;
                        end
                    end else if (load_use) begin
                        // One bubble: next cycle the load is in MEM and the
                        // forwarding path covers the dependency.
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        reset_id_ex = RESET_RESET;
                    end
                end

                HZ_PEND: begin
                    // EX only sees bubbles here, so ex_redirect is not acted on.
                    if (bus.Iwait) begin
                        reset_id_ex = RESET_RESET;
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                    end else begin
                        // The returning fetch is wrong-path: discard it and
                        // steer the PC to the parked target.
                        redirect_valid = 1'b1;
                        redirect_pc    = pend_pc_q;
                        reset_if_id    = RESET_RESET;
                        reset_id_ex    = RESET_RESET;
                        flush_count_d  = flush_count_q + CNT_W'(1);
                        state_d        = HZ_IDLE;
                    end
                end

                default: begin
                    state_d = HZ_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Drive the interface
    // -------------------------------------------------------------------------
    assign bus.reset_IF_ID    = reset_if_id;
    assign bus.reset_ID_EX    = reset_id_ex;
    assign bus.stall_pc       = stall_pc;
    assign bus.stall_IF_ID    = stall_if_id;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.flush_count    = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Directed scenarios compare against
// hand-written expected controls; the randomized phase compares against a
// behavioural model that tracks only "is a redirect outstanding, to where"
// and the number of redirects applied.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    typedef struct packed {
        reset_t            rif;
        reset_t            rid;
        logic              spc;
        logic              sif;
        logic              rv;
        logic [XLEN-1:0]   rpc;
        logic [CNT_W-1:0]  cnt;
    } obs_t;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic              m_pending = 1'b0;
    logic [XLEN-1:0]   m_pc      = '0;
    logic [CNT_W-1:0]  m_count   = '0;

    hazard_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic obs_t mk(input reset_t rif, input reset_t rid, input logic spc,
                                input logic sif, input logic rv,
                                input logic [XLEN-1:0] rpc, input logic [CNT_W-1:0] cnt);
        obs_t o;
        o.rif = rif; o.rid = rid; o.spc = spc; o.sif = sif;
        o.rv  = rv;  o.rpc = rpc; o.cnt = cnt;
        return o;
    endfunction

    function automatic obs_t observe();
        return mk(bus.reset_IF_ID, bus.reset_ID_EX, bus.stall_pc, bus.stall_IF_ID,
                  bus.redirect_valid, bus.redirect_pc, bus.flush_count);
    endfunction

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_dst = '0; bus.ex_regwrite = 1'b0; bus.ex_is_load = 1'b0;
        bus.ex_redirect = 1'b0; bus.ex_target = '0;
        bus.Iwait = 1'b0; bus.Dwait = 1'b0; bus.exe_is_waiting = 1'b0;
    endtask

    // Expected controls from the behavioural rules.
    function automatic obs_t model_expect();
        obs_t            e;
        logic            frozen;
        logic            dep;
        logic [XLEN-1:0] tgt;
        e = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b0, 1'b0, 1'b0, '0, m_count);
        frozen = bus.Dwait | bus.exe_is_waiting;
        dep = bus.ex_is_load && bus.ex_regwrite && (bus.ex_dst != 5'd0) &&
              ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_dst) ||
               (bus.id_use_rs2 && bus.id_rs2 == bus.ex_dst));
        if (reset) begin
            e = mk(RESET_RESET, RESET_RESET, 1'b0, 1'b0, 1'b0, '0, '0);
        end else if (frozen) begin
            e.spc = 1'b1; e.sif = 1'b1;
        end else if (m_pending || bus.ex_redirect) begin
            tgt = m_pending ? m_pc : bus.ex_target;
            if (bus.Iwait) begin
                e.rid = RESET_RESET; e.spc = 1'b1; e.sif = 1'b1;
            end else begin
                e.rif = RESET_RESET; e.rid = RESET_RESET; e.rv = 1'b1; e.rpc = tgt;
            end
        end else if (dep) begin
            e.rid = RESET_RESET; e.spc = 1'b1; e.sif = 1'b1;
        end
        return e;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_pending = 1'b0; m_pc = '0; m_count = '0;
        end else if (!(bus.Dwait || bus.exe_is_waiting)) begin
            if (m_pending || bus.ex_redirect) begin
                if (!bus.Iwait) begin
                    m_pending = 1'b0;
                    m_count   = m_count + 1;
                end else if (!m_pending) begin
                    m_pending = 1'b1;
                    m_pc      = bus.ex_target;
                end
            end
        end
    endtask

    // Advance one clock; inputs stay stable across the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        obs_t act, exp;
        idle();
        reset = 1'b1;
        #1;
        exp = mk(RESET_RESET, RESET_RESET, 1'b0, 1'b0, 1'b0, '0, '0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL reset_outputs: got %h expected %h", act, exp); end
        tick(); tick();
        reset = 1'b0;
        #1;
        exp = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b0, 1'b0, 1'b0, '0, '0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL after_reset_idle: got %h expected %h", act, exp); end
        tick();
    endtask

    task automatic test_load_use();
        obs_t act, exp;
        idle();
        bus.ex_is_load = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_dst = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
        #1;
        exp = mk(RESET_CONTINUE, RESET_RESET, 1'b1, 1'b1, 1'b0, '0, '0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL load_use_rs1: got %h expected %h", act, exp); end
        tick();
        bus.ex_is_load = 1'b0; bus.ex_regwrite = 1'b0;
        #1;
        exp = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b0, 1'b0, 1'b0, '0, '0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL load_use_release: got %h expected %h", act, exp); end
        tick();
        // rs2 path
        idle();
        bus.ex_is_load = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_dst = 5'd7;
        bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1; bus.id_rs1 = 5'd7;
        #1;
        exp = mk(RESET_CONTINUE, RESET_RESET, 1'b1, 1'b1, 1'b0, '0, '0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL load_use_rs2: got %h expected %h", act, exp); end
        tick();
        // Same registers but neither source actually read
        bus.id_use_rs2 = 1'b0;
        #1;
        exp = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b0, 1'b0, 1'b0, '0, '0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL load_use_unused_src: got %h expected %h", act, exp); end
        tick();
    endtask

    task automatic test_redirect();
        obs_t act, exp;
        idle();
        bus.ex_redirect = 1'b1; bus.ex_target = 64'h8000_0040;
        #1;
        exp = mk(RESET_RESET, RESET_RESET, 1'b0, 1'b0, 1'b1, 64'h8000_0040, 32'd0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL redirect_now: got %h expected %h", act, exp); end
        tick();
        idle();
        #1;
        exp = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b0, 1'b0, 1'b0, '0, 32'd1);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL redirect_count: got %h expected %h", act, exp); end
        tick();
    endtask

    task automatic test_pend();
        obs_t act, exp;
        idle();
        bus.ex_redirect = 1'b1; bus.ex_target = 64'h8000_0100; bus.Iwait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            exp = mk(RESET_CONTINUE, RESET_RESET, 1'b1, 1'b1, 1'b0, '0, 32'd1);
            act = observe(); checks++;
            if (act !== exp) begin errors++; $display("FAIL pend_wait%0d: got %h expected %h", i, act, exp); end
            tick();
            // A new redirect while pending must not replace the parked target.
            bus.ex_target = 64'h0000_1234;
        end
        bus.Iwait = 1'b0; bus.ex_redirect = 1'b0;
        #1;
        exp = mk(RESET_RESET, RESET_RESET, 1'b0, 1'b0, 1'b1, 64'h8000_0100, 32'd1);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL pend_release: got %h expected %h", act, exp); end
        tick();
        idle();
        #1;
        exp = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b0, 1'b0, 1'b0, '0, 32'd2);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL pend_back_idle: got %h expected %h", act, exp); end
        tick();
    endtask

    task automatic test_gstall();
        obs_t act, exp;
        idle();
        bus.ex_redirect = 1'b1; bus.ex_target = 64'h8000_0200; bus.Iwait = 1'b1;
        tick();
        bus.ex_target = 64'h0000_dead; bus.Dwait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) bus.Iwait = 1'b0;
            if (i == 2) begin bus.Dwait = 1'b0; bus.exe_is_waiting = 1'b1; end
            #1;
            exp = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b1, 1'b1, 1'b0, '0, 32'd2);
            act = observe(); checks++;
            if (act !== exp) begin errors++; $display("FAIL gstall_pend%0d: got %h expected %h", i, act, exp); end
            tick();
        end
        bus.exe_is_waiting = 1'b0; bus.ex_redirect = 1'b0;
        #1;
        exp = mk(RESET_RESET, RESET_RESET, 1'b0, 1'b0, 1'b1, 64'h8000_0200, 32'd2);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL gstall_release: got %h expected %h", act, exp); end
        tick();
        // Global stall in IDLE swallows a concurrent redirect
        idle();
        bus.Dwait = 1'b1; bus.ex_redirect = 1'b1; bus.ex_target = 64'h8000_0300;
        #1;
        exp = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b1, 1'b1, 1'b0, '0, 32'd3);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL gstall_idle_redirect: got %h expected %h", act, exp); end
        tick();
        idle();
        #1;
        exp = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b0, 1'b0, 1'b0, '0, 32'd3);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL gstall_no_count: got %h expected %h", act, exp); end
        tick();
    endtask

    task automatic test_async_reset();
        obs_t act, exp;
        idle();
        bus.ex_redirect = 1'b1; bus.ex_target = 64'h8000_0300; bus.Iwait = 1'b1;
        tick();
        bus.ex_redirect = 1'b0;
        #2;
        reset = 1'b1;
        m_pending = 1'b0; m_pc = '0; m_count = '0;
        #1;
        exp = mk(RESET_RESET, RESET_RESET, 1'b0, 1'b0, 1'b0, '0, '0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL async_reset: got %h expected %h", act, exp); end
        tick();
        reset = 1'b0;
        bus.Iwait = 1'b0;
        #1;
        exp = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b0, 1'b0, 1'b0, '0, '0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL reset_drops_pend: got %h expected %h", act, exp); end
        tick();
        #1;
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL reset_drops_pend2: got %h expected %h", act, exp); end
        tick();
    endtask

    task automatic test_x0_and_priority();
        obs_t act, exp;
        idle();
        bus.ex_is_load = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_dst = 5'd0;
        bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
        #1;
        exp = mk(RESET_CONTINUE, RESET_CONTINUE, 1'b0, 1'b0, 1'b0, '0, '0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL load_x0: got %h expected %h", act, exp); end
        tick();
        bus.ex_dst = 5'd5; bus.id_rs1 = 5'd5;
        bus.ex_redirect = 1'b1; bus.ex_target = 64'h8000_0400;
        #1;
        exp = mk(RESET_RESET, RESET_RESET, 1'b0, 1'b0, 1'b1, 64'h8000_0400, '0);
        act = observe(); checks++;
        if (act !== exp) begin errors++; $display("FAIL redirect_over_loaduse: got %h expected %h", act, exp); end
        tick();
        idle();
    endtask

    task automatic test_random();
        obs_t act, exp;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            if (reset) begin m_pending = 1'b0; m_pc = '0; m_count = '0; end
            bus.id_rs1         = 5'($urandom_range(0, 3));
            bus.id_rs2         = 5'($urandom_range(0, 3));
            bus.id_use_rs1     = ($urandom_range(0, 3) != 0);
            bus.id_use_rs2     = ($urandom_range(0, 1) != 0);
            bus.ex_dst         = 5'($urandom_range(0, 3));
            bus.ex_regwrite    = ($urandom_range(0, 3) != 0);
            bus.ex_is_load     = ($urandom_range(0, 1) != 0);
            bus.ex_redirect    = ($urandom_range(0, 5) == 0);
            bus.ex_target      = {$urandom, $urandom};
            bus.Iwait          = ($urandom_range(0, 1) != 0);
            bus.Dwait          = ($urandom_range(0, 7) == 0);
            bus.exe_is_waiting = ($urandom_range(0, 7) == 0);
            #1;
            exp = model_expect();
            act = observe(); checks++;
            if (act !== exp) begin errors++; $display("FAIL random_cycle%0d: got %h expected %h", n, act, exp); end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_redirect();
        test_pend();
        test_gstall();
        test_async_reset();
        test_x0_and_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
